// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control unit: state codes, opcodes,
// immediate formats, branch funct3 values and ALU status bit positions.
package cpu_ctrl_pkg;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WRBK   = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] OP_RALU   = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_U = 2'b11;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam int ST_N = 3;
    localparam int ST_Z = 2;
    localparam int ST_C = 1;
    localparam int ST_V = 0;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_RALU,
        CLS_IALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_LUI
    } op_class_t;

    function automatic op_class_t classify(input logic [6:0] opcode);
        case (opcode)
            OP_RALU:   return CLS_RALU;
            OP_IALU:   return CLS_IALU;
            OP_LOAD:   return CLS_LOAD;
            OP_STORE:  return CLS_STORE;
            OP_BRANCH: return CLS_BRANCH;
            OP_LUI:    return CLS_LUI;
            default:   return CLS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/cpu_control_fsm_branch_eval.sv
// Branch condition evaluator: resolves taken from funct3 and the ALU flags,
// and reports whether funct3 names a supported branch at all.
module branch_eval
    import cpu_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [3:0] status,
    output logic       taken,
    output logic       valid
);

    logic unused_carry;
    assign unused_carry = status[ST_C];

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        taken = 1'b0;
        valid = 1'b1;
        case (funct3)
            F3_BEQ:  taken = status[ST_Z];
            F3_BNE:  taken = ~status[ST_Z];
            F3_BLT:  taken = status[ST_N] ^ status[ST_V];
            F3_BGE:  taken = ~(status[ST_N] ^ status[ST_V]);
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multicycle control unit: sequences each instruction through fetch, decode,
// execute, memory and writeback, stalling on the memory-ready handshake.
module cpu_control_fsm
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [3:0]  status,
    input  logic        memready,
    output logic        pcsel,
    output logic        pcwr,
    output logic        irwr,
    output logic        enwri,
    output logic        alusrc,
    output logic        wb,
    output logic        mrw,
    output logic        memen,
    output logic [1:0]  immxsel,
    output logic        illegal
);

    logic [2:0] state, next_state;
    logic [6:0] opcode_q;
    logic [2:0] funct3_q;
    op_class_t  cls;
    logic       br_taken, br_valid;

    logic unused_instr;
    assign unused_instr = ^{instr[31:15], instr[11:7]};

    assign cls = classify(opcode_q);

    branch_eval u_branch (
        .funct3 (funct3_q),
        .status (status),
        .taken  (br_taken),
        .valid  (br_valid)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            opcode_q <= '0;
            funct3_q <= '0;
        end else begin
            state <= next_state;
            if (state == S_FETCH && memready) begin
                opcode_q <= instr[6:0];
                funct3_q <= instr[14:12];
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  if (memready) next_state = S_DECODE;
            S_DECODE: begin
                if (cls == CLS_NONE || (cls == CLS_BRANCH && !br_valid))
                    next_state = S_TRAP;
                else
                    next_state = S_EXEC;
            end
            S_EXEC: begin
                case (cls)
                    CLS_BRANCH:          next_state = S_FETCH;
                    CLS_LOAD, CLS_STORE: next_state = S_MEM;
                    default:             next_state = S_WRBK;
                endcase
            end
            S_MEM: begin
                if (memready) next_state = (cls == CLS_STORE) ? S_FETCH : S_WRBK;
            end
            S_WRBK:  next_state = S_FETCH;
            S_TRAP:  next_state = S_TRAP;
            default: next_state = S_FETCH;
        endcase
    end

    // Operand selection from EXEC is held through MEM and WRBK.
    logic       op_alusrc;
    logic [1:0] op_imm;

    always_comb begin
        op_alusrc = (cls == CLS_IALU) || (cls == CLS_LOAD) ||
                    (cls == CLS_STORE) || (cls == CLS_LUI);
        case (cls)
            CLS_STORE:  op_imm = IMM_S;
            CLS_BRANCH: op_imm = IMM_B;
            CLS_LUI:    op_imm = IMM_U;
            default:    op_imm = IMM_I;
        endcase
    end

    logic       pcsel_d, pcwr_d, irwr_d, enwri_d, alusrc_d, wb_d, mrw_d, memen_d, illegal_d;
    logic [1:0] immxsel_d;

    always_comb begin
        pcsel_d   = 1'b0;
        pcwr_d    = 1'b0;
        irwr_d    = 1'b0;
        enwri_d   = 1'b0;
        alusrc_d  = 1'b0;
        wb_d      = 1'b0;
        mrw_d     = 1'b0;
        memen_d   = 1'b0;
        illegal_d = 1'b0;
        immxsel_d = IMM_I;
        case (state)
            S_FETCH: begin
                irwr_d = memready;
                pcwr_d = memready;
            end
            S_EXEC: begin
                alusrc_d  = op_alusrc;
                immxsel_d = op_imm;
                if (cls == CLS_BRANCH) begin
                    pcsel_d = 1'b1;
                    pcwr_d  = br_taken;
                end
            end
            S_MEM: begin
                alusrc_d  = op_alusrc;
                immxsel_d = op_imm;
                memen_d   = 1'b1;
                mrw_d     = (cls == CLS_STORE);
            end
            S_WRBK: begin
                alusrc_d  = op_alusrc;
                immxsel_d = op_imm;
                enwri_d   = 1'b1;
                wb_d      = (cls != CLS_LOAD);
            end
            S_TRAP:  illegal_d = 1'b1;
            default: ;
        endcase
    end

    // Outputs are held low for the whole time reset is asserted, not just after the next edge.
    assign pcsel   = rst_n & pcsel_d;
    assign pcwr    = rst_n & pcwr_d;
    assign irwr    = rst_n & irwr_d;
    assign enwri   = rst_n & enwri_d;
    assign alusrc  = rst_n & alusrc_d;
    assign wb      = rst_n & wb_d;
    assign mrw     = rst_n & mrw_d;
    assign memen   = rst_n & memen_d;
    assign illegal = rst_n & illegal_d;
    assign immxsel = rst_n ? immxsel_d : 2'b00;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: walks add, load, store, branches, trap
// and reset-abort sequences, checking every strobe cycle by cycle.
module tb_cpu_control_fsm;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [3:0]  status;
    logic        memready;
    logic        pcsel, pcwr, irwr, enwri, alusrc, wb, mrw, memen, illegal;
    logic [1:0]  immxsel;

    int total = 0;
    int bad   = 0;

    cpu_control_fsm dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .instr    (instr),
        .status   (status),
        .memready (memready),
        .pcsel    (pcsel),
        .pcwr     (pcwr),
        .irwr     (irwr),
        .enwri    (enwri),
        .alusrc   (alusrc),
        .wb       (wb),
        .mrw      (mrw),
        .memen    (memen),
        .immxsel  (immxsel),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed strobe vector: {pcsel,pcwr,irwr,enwri,alusrc,wb,mrw,memen,immxsel,illegal}
    function automatic logic [10:0] mk(input logic ps, input logic pw, input logic iw,
                                       input logic ew, input logic as, input logic w,
                                       input logic rw, input logic me, input logic [1:0] im,
                                       input logic il);
        return {ps, pw, iw, ew, as, w, rw, me, im, il};
    endfunction

    localparam logic [10:0] IDLE   = 11'b0;
    localparam logic [10:0] F_RDY  = 11'b011_0000_0000;
    localparam logic [10:0] TRAPPED = 11'b000_0000_0001;

    task automatic check(input string tag, input logic [10:0] expected);
        logic [10:0] observed;
        observed = {pcsel, pcwr, irwr, enwri, alusrc, wb, mrw, memen, immxsel, illegal};
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Advance to the next cycle, then drive memready for it and let logic settle.
    task automatic tick(input logic mr);
        @(posedge clk);
        #2 memready = mr;
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        memready = 1'b1;
        instr    = 32'h002081B3;
        status   = 4'b0000;

        repeat (3) begin
            tick(1'b1);
            check("reset_forced_zero", IDLE);
        end
        memready = 1'b0;
        #1 rst_n = 1'b1;
        #1 check("reset_release_stalled", IDLE);

        // add: FETCH, DECODE, EXEC, WRBK
        tick(1'b1); check("add_fetch", F_RDY);
        tick(1'b1); check("add_decode", IDLE);
        tick(1'b1); check("add_exec", IDLE);
        tick(1'b1); check("add_wrbk", mk(0,0,0,1,0,1,0,0,2'b00,0));
        tick(1'b0); check("add_next_fetch_stall", IDLE);

        // lw with two MEM stall cycles: 7 cycles total
        instr = 32'h0000A103;
        tick(1'b1); check("lw_fetch", F_RDY);
        tick(1'b1); check("lw_decode", IDLE);
        tick(1'b1); check("lw_exec", mk(0,0,0,0,1,0,0,0,2'b00,0));
        tick(1'b0); check("lw_mem_stall1", mk(0,0,0,0,1,0,0,1,2'b00,0));
        tick(1'b0); check("lw_mem_stall2", mk(0,0,0,0,1,0,0,1,2'b00,0));
        tick(1'b1); check("lw_mem_ready", mk(0,0,0,0,1,0,0,1,2'b00,0));
        tick(1'b1); check("lw_wrbk", mk(0,0,0,1,1,0,0,0,2'b00,0));
        tick(1'b0); check("lw_next_fetch_stall", IDLE);

        // sw: FETCH, DECODE, EXEC, MEM, then FETCH
        instr = 32'h0020A023;
        tick(1'b1); check("sw_fetch", F_RDY);
        tick(1'b1); check("sw_decode", IDLE);
        tick(1'b1); check("sw_exec", mk(0,0,0,0,1,0,0,0,2'b01,0));
        tick(1'b1); check("sw_mem", mk(0,0,0,0,1,0,1,1,2'b01,0));
        instr  = 32'h00208463;
        status = 4'b0100;
        tick(1'b1); check("sw_back_to_fetch", F_RDY);

        // BEQ taken (Z=1)
        tick(1'b1); check("beq_t_decode", IDLE);
        tick(1'b1); check("beq_t_exec", mk(1,1,0,0,0,0,0,0,2'b10,0));
        status = 4'b0000;
        tick(1'b1); check("beq_nt_fetch", F_RDY);
        tick(1'b1); check("beq_nt_decode", IDLE);
        tick(1'b1); check("beq_nt_exec", mk(1,0,0,0,0,0,0,0,2'b10,0));

        // BLT taken with N=1, V=0
        instr  = 32'h0020C463;
        status = 4'b1000;
        tick(1'b1); check("blt_fetch", F_RDY);
        tick(1'b1); check("blt_decode", IDLE);
        tick(1'b1); check("blt_exec", mk(1,1,0,0,0,0,0,0,2'b10,0));

        // BGE not taken with N=1, V=0
        instr = 32'h0020D463;
        tick(1'b1); check("bge_fetch", F_RDY);
        tick(1'b1); check("bge_decode", IDLE);
        tick(1'b1); check("bge_exec", mk(1,0,0,0,0,0,0,0,2'b10,0));

        // Undecodable instruction traps and stays trapped
        instr = 32'hFFFFFFFF;
        tick(1'b1); check("ill_fetch", F_RDY);
        tick(1'b1); check("ill_decode", IDLE);
        for (int i = 0; i < 20; i++) begin
            tick(i[0]);
            check("trap_sticky", TRAPPED);
        end
        rst_n = 1'b0;
        #1 check("trap_reset_clears", IDLE);
        tick(1'b1); check("trap_reset_held", IDLE);
        memready = 1'b0;
        rst_n    = 1'b1;
        #1 check("trap_release_stalled", IDLE);

        // Branch opcode with unsupported funct3 also traps
        instr = 32'h0020A463;
        tick(1'b1); check("badbr_fetch", F_RDY);
        tick(1'b1); check("badbr_decode", IDLE);
        tick(1'b1); check("badbr_trap", TRAPPED);
        rst_n = 1'b0;
        #1 check("badbr_reset_clears", IDLE);
        tick(1'b1);
        memready = 1'b0;
        rst_n    = 1'b1;
        #1 check("badbr_release_stalled", IDLE);

        // Reset during MEM of a load aborts it without a writeback
        instr = 32'h0000A103;
        tick(1'b1); check("abort_fetch", F_RDY);
        tick(1'b1); check("abort_decode", IDLE);
        tick(1'b1); check("abort_exec", mk(0,0,0,0,1,0,0,0,2'b00,0));
        tick(1'b0); check("abort_mem", mk(0,0,0,0,1,0,0,1,2'b00,0));
        #2 rst_n = 1'b0;
        #1 check("abort_immediate_zero", IDLE);
        tick(1'b1); check("abort_held1", IDLE);
        tick(1'b1); check("abort_held2", IDLE);
        memready = 1'b0;
        rst_n    = 1'b1;
        #1 check("abort_release_stalled", IDLE);
        tick(1'b1); check("abort_restart_fetch", F_RDY);
        tick(1'b1); check("abort_restart_decode", IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
